// File: rtl/tank_input_ctrl.sv
// tank_input_ctrl: input conditioning ahead of the ultra_tank core.
//   Synchronises and debounces the 13 raw buttons, decodes each player's
//   8-way direction into two-lever tread commands, inserts a dead time on
//   forward<->back tread reversals, and stretches a coin press into a fixed
//   active-low pulse.
// Ports:
//   clk_sys, Reset_n (async, active-low)
//   p1_dir_i/p2_dir_i {up,down,left,right}, fire_i {p2,p1}, coin_i,
//   start_i {start2,start1}         raw, active-high
//   JoyW/X (p1), JoyY/Z (p2) _Fw_O/_Bk_O  tread commands, active-low
//   FireA_O/FireB_O                 fire, active-high
//   Coin_O                          coin pulse, active-low
//   Start1_O/Start2_O               start level, active-low

// One button: 2-flop synchroniser plus counting debouncer.
module tank_deb #(
  parameter int DEB_CYCLES = 120000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '0;
      deb  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      // any return to the debounced value restarts the count
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// One tread: follows the Fw/Bk target, but a direct Fw<->Bk flip passes
// through REV_GAP cycles with both levers released.
module tank_tread #(
  parameter int REV_GAP = 12000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic tgt_fw,
  input  logic tgt_bk,
  output logic fw_n,
  output logic bk_n
);
  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_FW   = 2'd1;
  localparam logic [1:0] T_BK   = 2'd2;
  localparam logic [1:0] T_GAP  = 2'd3;

  localparam int GW = (REV_GAP > 0) ? $clog2(REV_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (REV_GAP > 0) ? GW'(REV_GAP - 1) : '0;

  logic [1:0]    state, nxt, tgt_st;
  logic [GW-1:0] cnt, cnt_nxt;

  always_comb begin
    tgt_st = T_IDLE;
    if (tgt_fw && !tgt_bk)      tgt_st = T_FW;
    else if (tgt_bk && !tgt_fw) tgt_st = T_BK;
    nxt     = tgt_st;
    cnt_nxt = '0;
    case (state)
      T_FW:  if (tgt_st == T_BK && REV_GAP > 0) begin
               nxt     = T_GAP;
               cnt_nxt = GAP_LOAD;
             end
      T_BK:  if (tgt_st == T_FW && REV_GAP > 0) begin
               nxt     = T_GAP;
               cnt_nxt = GAP_LOAD;
             end
      // target changes during the gap are only looked at on exit
      T_GAP: if (cnt != '0) begin
               nxt     = T_GAP;
               cnt_nxt = cnt - 1'b1;
             end
      default: ;
    endcase
  end

  // outputs registered from the next state so they are glitch-free flops
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state <= T_IDLE;
      cnt   <= '0;
      fw_n  <= 1'b1;
      bk_n  <= 1'b1;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      fw_n  <= (nxt != T_FW);
      bk_n  <= (nxt != T_BK);
    end
  end
endmodule

module tank_input_ctrl #(
  parameter int DEB_CYCLES = 120000,
  parameter int COIN_PULSE = 240000,
  parameter int REV_GAP    = 12000
) (
  input  logic       clk_sys,
  input  logic       Reset_n,
  input  logic [3:0] p1_dir_i,
  input  logic [3:0] p2_dir_i,
  input  logic [1:0] fire_i,
  input  logic       coin_i,
  input  logic [1:0] start_i,
  output logic       JoyW_Fw_O,
  output logic       JoyW_Bk_O,
  output logic       JoyX_Fw_O,
  output logic       JoyX_Bk_O,
  output logic       JoyY_Fw_O,
  output logic       JoyY_Bk_O,
  output logic       JoyZ_Fw_O,
  output logic       JoyZ_Bk_O,
  output logic       FireA_O,
  output logic       FireB_O,
  output logic       Coin_O,
  output logic       Start1_O,
  output logic       Start2_O
);
  localparam int NUM_BTN = 13;
  localparam int NUM_TRD = 4;

  // [3:0] p1 dir, [7:4] p2 dir, [9:8] fire, [10] coin, [12:11] start
  logic [NUM_BTN-1:0] raw, deb_q;
  assign raw = {start_i, coin_i, fire_i, p2_dir_i, p1_dir_i};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_deb
    tank_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_sys (clk_sys),
      .rst_n   (Reset_n),
      .raw     (raw[b]),
      .deb     (deb_q[b])
    );
  end

  // {u,d,l,r} -> {leftFw,leftBk,rightFw,rightBk}; contradictory or
  // 3+ key combinations release everything
  function automatic logic [3:0] dir_decode(input logic [3:0] k);
    case (k)
      4'b1010: dir_decode = 4'b0010;
      4'b1000: dir_decode = 4'b1010;
      4'b1001: dir_decode = 4'b1000;
      4'b0001: dir_decode = 4'b1001;
      4'b0101: dir_decode = 4'b0100;
      4'b0100: dir_decode = 4'b0101;
      4'b0110: dir_decode = 4'b0001;
      4'b0010: dir_decode = 4'b0110;
      default: dir_decode = 4'b0000;
    endcase
  endfunction

  // tread order W, X, Y, Z; each entry {fw,bk}
  logic [NUM_TRD-1:0][1:0] tgt;
  logic [NUM_TRD-1:0]      fw_n, bk_n;

  for (genvar p = 0; p < 2; p++) begin : g_pl
    assign {tgt[2*p], tgt[2*p+1]} = dir_decode(deb_q[4*p +: 4]);
  end

  for (genvar t = 0; t < NUM_TRD; t++) begin : g_trd
    tank_tread #(.REV_GAP(REV_GAP)) u_tread (
      .clk_sys (clk_sys),
      .rst_n   (Reset_n),
      .tgt_fw  (tgt[t][1]),
      .tgt_bk  (tgt[t][0]),
      .fw_n    (fw_n[t]),
      .bk_n    (bk_n[t])
    );
  end

  assign JoyW_Fw_O = fw_n[0];
  assign JoyW_Bk_O = bk_n[0];
  assign JoyX_Fw_O = fw_n[1];
  assign JoyX_Bk_O = bk_n[1];
  assign JoyY_Fw_O = fw_n[2];
  assign JoyY_Bk_O = bk_n[2];
  assign JoyZ_Fw_O = fw_n[3];
  assign JoyZ_Bk_O = bk_n[3];

  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      FireA_O  <= 1'b0;
      FireB_O  <= 1'b0;
      Start1_O <= 1'b1;
      Start2_O <= 1'b1;
    end else begin
      FireA_O  <= deb_q[8];
      FireB_O  <= deb_q[9];
      Start1_O <= ~deb_q[11];
      Start2_O <= ~deb_q[12];
    end
  end

  // coin: one fixed pulse per press, re-armed only by a release seen
  // outside the pulse
  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_PULSE = 2'd1;
  localparam logic [1:0] C_WAIT  = 2'd2;

  localparam int CW = $clog2(COIN_PULSE + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(COIN_PULSE - 1);

  logic [1:0]    coin_st;
  logic [CW-1:0] coin_cnt;
  logic          coin_d, coin_prev;

  assign coin_d = deb_q[10];

  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      coin_st   <= C_IDLE;
      coin_cnt  <= '0;
      coin_prev <= 1'b0;
      Coin_O    <= 1'b1;
    end else begin
      coin_prev <= coin_d;
      case (coin_st)
        C_IDLE:
          if (coin_d && !coin_prev) begin
            coin_st  <= C_PULSE;
            coin_cnt <= PULSE_LOAD;
            Coin_O   <= 1'b0;
          end
        C_PULSE:
          if (coin_cnt == '0) begin
            coin_st <= coin_d ? C_WAIT : C_IDLE;
            Coin_O  <= 1'b1;
          end else begin
            coin_cnt <= coin_cnt - 1'b1;
          end
        C_WAIT:
          if (!coin_d) coin_st <= C_IDLE;
        default: begin
          coin_st <= C_IDLE;
          Coin_O  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tank_input_ctrl.sv
module tb_tank_input_ctrl;
  localparam int DEB  = 4;
  localparam int CP   = 6;
  localparam int GAP  = 3;
  localparam logic [12:0] RST_OUT = 13'b1111111100111;

  logic       clk_sys = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] p1_dir_i = '0, p2_dir_i = '0;
  logic [1:0] fire_i = '0, start_i = '0;
  logic       coin_i = 1'b0;
  logic JoyW_Fw_O, JoyW_Bk_O, JoyX_Fw_O, JoyX_Bk_O;
  logic JoyY_Fw_O, JoyY_Bk_O, JoyZ_Fw_O, JoyZ_Bk_O;
  logic FireA_O, FireB_O, Coin_O, Start1_O, Start2_O;

  always #5 clk_sys = ~clk_sys;

  tank_input_ctrl #(.DEB_CYCLES(DEB), .COIN_PULSE(CP), .REV_GAP(GAP)) dut (
    .clk_sys(clk_sys), .Reset_n(Reset_n),
    .p1_dir_i(p1_dir_i), .p2_dir_i(p2_dir_i), .fire_i(fire_i),
    .coin_i(coin_i), .start_i(start_i),
    .JoyW_Fw_O(JoyW_Fw_O), .JoyW_Bk_O(JoyW_Bk_O),
    .JoyX_Fw_O(JoyX_Fw_O), .JoyX_Bk_O(JoyX_Bk_O),
    .JoyY_Fw_O(JoyY_Fw_O), .JoyY_Bk_O(JoyY_Bk_O),
    .JoyZ_Fw_O(JoyZ_Fw_O), .JoyZ_Bk_O(JoyZ_Bk_O),
    .FireA_O(FireA_O), .FireB_O(FireB_O), .Coin_O(Coin_O),
    .Start1_O(Start1_O), .Start2_O(Start2_O)
  );

  logic [12:0] out_vec;
  assign out_vec = {JoyW_Fw_O, JoyW_Bk_O, JoyX_Fw_O, JoyX_Bk_O,
                    JoyY_Fw_O, JoyY_Bk_O, JoyZ_Fw_O, JoyZ_Bk_O,
                    FireA_O, FireB_O, Coin_O, Start1_O, Start2_O};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // debounced level: flips once the synchronised input (raw delayed 2 edges)
  // has disagreed with it for DEB consecutive edges
  logic [12:0] m_deb;
  logic [12:0] m_hist[$];
  int          m_dir[4];   // 0 none, 1 forward, 2 back
  int          m_gap[4];   // released cycles still owed
  int          m_pulse;
  bit          m_hold, m_cprev;
  logic [12:0] m_exp;

  function automatic int sgn(input int x);
    return (x > 0) ? 1 : (x < 0) ? -1 : 0;
  endfunction

  // stick as vertical/horizontal axes; steering is mirrored when backing up
  function automatic logic [3:0] ref_dec(input logic [3:0] k);
    int v, h, l, r;
    if ((k[3] && k[2]) || (k[1] && k[0])) return 4'b0000;
    v = int'(k[3]) - int'(k[2]);
    h = int'(k[0]) - int'(k[1]);
    if (v >= 0) begin l = sgn(v + h); r = sgn(v - h); end
    else        begin l = sgn(v - h); r = sgn(v + h); end
    return {l > 0, l < 0, r > 0, r < 0};
  endfunction

  task automatic model_reset();
    m_deb = '0;
    m_hist.delete();
    for (int j = 0; j < DEB + 2; j++) m_hist.push_back('0);
    for (int i = 0; i < 4; i++) begin m_dir[i] = 0; m_gap[i] = 0; end
    m_pulse = 0; m_hold = 0; m_cprev = 0;
    m_exp = RST_OUT;
  endtask

  task automatic model_step();
    logic [7:0] tg;
    int         want;
    bit         c, flip;
    tg = {ref_dec(m_deb[3:0]), ref_dec(m_deb[7:4])};
    for (int i = 0; i < 4; i++) begin
      want = tg[7-2*i] ? 1 : tg[6-2*i] ? 2 : 0;
      if (m_gap[i] > 0) begin
        m_gap[i]--;
        if (m_gap[i] == 0) m_dir[i] = want;
      end else if (GAP > 0 && m_dir[i] != 0 && want != 0 && want != m_dir[i]) begin
        m_gap[i] = GAP;
        m_dir[i] = 0;
      end else begin
        m_dir[i] = want;
      end
      m_exp[12-2*i] = (m_dir[i] != 1);
      m_exp[11-2*i] = (m_dir[i] != 2);
    end
    c = m_deb[10];
    if (m_pulse > 0) begin
      m_pulse--;
      if (m_pulse == 0) m_hold = c;
    end else if (m_hold) begin
      if (!c) m_hold = 0;
    end else if (c && !m_cprev) begin
      m_pulse = CP;
    end
    m_cprev = c;
    m_exp[4] = m_deb[8];
    m_exp[3] = m_deb[9];
    m_exp[2] = (m_pulse == 0);
    m_exp[1] = ~m_deb[11];
    m_exp[0] = ~m_deb[12];
    // debounced levels after this edge
    m_hist.push_front({start_i, coin_i, fire_i, p2_dir_i, p1_dir_i});
    if (m_hist.size() > DEB + 2) void'(m_hist.pop_back());
    for (int b = 0; b < 13; b++) begin
      flip = 1;
      for (int j = 2; j <= DEB + 1; j++)
        if (m_hist[j][b] == m_deb[b]) flip = 0;
      if (flip) m_deb[b] = ~m_deb[b];
    end
  endtask

  // one clock: advance the model, then compare every output
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_sys);
      model_step();
      #1;
      chk("cycle", 32'(out_vec), 32'(m_exp));
    end
  endtask

  task automatic do_reset();
    @(posedge clk_sys); #1;
    Reset_n = 1'b0;
    p1_dir_i = '0; p2_dir_i = '0; fire_i = '0; coin_i = 1'b0; start_i = '0;
    #1 chk("rst_out", 32'(out_vec), 32'(RST_OUT));
    repeat (2) @(posedge clk_sys);
    #1 Reset_n = 1'b1;
    model_reset();
  endtask

  int lowc;

  initial begin
    model_reset();
    do_reset();
    tick(20);
    chk("rst_hold", 32'(out_vec), 32'(RST_OUT));

    // short glitch rejected
    p1_dir_i = 4'b0001; tick(3);
    p1_dir_i = 4'b0000; tick(10);
    chk("glitch", 32'({JoyW_Fw_O, JoyW_Bk_O, JoyX_Fw_O, JoyX_Bk_O}), 32'hF);

    // up: 7-cycle latency
    p1_dir_i = 4'b1000; tick(6);
    chk("up_pre", 32'({JoyW_Fw_O, JoyX_Fw_O}), 32'h3);
    tick(1);
    chk("up_lat", 32'({JoyW_Fw_O, JoyW_Bk_O, JoyX_Fw_O, JoyX_Bk_O}), 32'b0101);
    tick(10);

    // up -> down: 3 released cycles then back
    p1_dir_i = 4'b0100; tick(7);
    chk("rev_gap_a", 32'({JoyW_Fw_O, JoyW_Bk_O, JoyX_Fw_O, JoyX_Bk_O}), 32'hF);
    tick(2);
    chk("rev_gap_b", 32'({JoyW_Fw_O, JoyW_Bk_O, JoyX_Fw_O, JoyX_Bk_O}), 32'hF);
    tick(1);
    chk("rev_bk", 32'({JoyW_Fw_O, JoyW_Bk_O, JoyX_Fw_O, JoyX_Bk_O}), 32'b1010);
    tick(10);

    // back to up, then up-right releases only X with no gap
    p1_dir_i = 4'b1000; tick(20);
    p1_dir_i = 4'b1001; tick(6);
    chk("ur_pre", 32'({JoyX_Fw_O, JoyX_Bk_O}), 32'b01);
    tick(1);
    chk("ur_lat", 32'({JoyW_Fw_O, JoyW_Bk_O, JoyX_Fw_O, JoyX_Bk_O}), 32'b0111);
    p1_dir_i = 4'b0000; tick(10);

    // p2 invalid combos release everything; left pivots
    p2_dir_i = 4'b1100; tick(12);
    chk("p2_ud", 32'({JoyY_Fw_O, JoyY_Bk_O, JoyZ_Fw_O, JoyZ_Bk_O}), 32'hF);
    p2_dir_i = 4'b0011; tick(12);
    chk("p2_lr", 32'({JoyY_Fw_O, JoyY_Bk_O, JoyZ_Fw_O, JoyZ_Bk_O}), 32'hF);
    p2_dir_i = 4'b1110; tick(12);
    chk("p2_three", 32'({JoyY_Fw_O, JoyY_Bk_O, JoyZ_Fw_O, JoyZ_Bk_O}), 32'hF);
    p2_dir_i = 4'b0010; tick(12);
    chk("p2_left", 32'({JoyY_Fw_O, JoyY_Bk_O, JoyZ_Fw_O, JoyZ_Bk_O}), 32'b1001);
    p2_dir_i = 4'b0000; tick(10);

    // coin held: single pulse of CP cycles
    coin_i = 1'b1; lowc = 0;
    for (int k = 0; k < 50; k++) begin tick(1); if (!Coin_O) lowc++; end
    chk("coin_len", 32'(lowc), 32'(CP));
    coin_i = 1'b0; lowc = 0;
    for (int k = 0; k < 20; k++) begin tick(1); if (!Coin_O) lowc++; end
    chk("coin_norel", 32'(lowc), 32'd0);
    coin_i = 1'b1; lowc = 0;
    for (int k = 0; k < 20; k++) begin tick(1); if (!Coin_O) lowc++; end
    chk("coin_again", 32'(lowc), 32'(CP));
    coin_i = 1'b0; tick(15);

    // reset mid-pulse releases the coin immediately
    coin_i = 1'b1; tick(9);
    chk("coin_mid", 32'(Coin_O), 32'd0);
    Reset_n = 1'b0;
    #1 chk("coin_rst", 32'(Coin_O), 32'd1);
    do_reset();
    tick(10);

    // fire and start
    fire_i = 2'b01; start_i = 2'b10; tick(6);
    chk("fs_pre", 32'({FireA_O, Start2_O}), 32'b01);
    tick(1);
    chk("fs_lat", 32'({FireA_O, FireB_O, Start1_O, Start2_O}), 32'b1010);
    fire_i = '0; start_i = '0; tick(10);

    // reset mid-gap, then random traffic
    p1_dir_i = 4'b1000; tick(12);
    p1_dir_i = 4'b0100; tick(8);
    do_reset();
    for (int s = 0; s < 400; s++) begin
      p1_dir_i = 4'($urandom_range(0, 15));
      p2_dir_i = 4'($urandom_range(0, 15));
      fire_i   = 2'($urandom_range(0, 3));
      start_i  = 2'($urandom_range(0, 3));
      coin_i   = ($urandom_range(0, 3) == 0);
      tick($urandom_range(1, 12));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tank_input_ctrl.md
Name: tank_input_ctrl

Overview:
- Input conditioning stage directly upstream of the ultra_tank core.
- Takes the merged per-player keyboard/joystick buttons (up/down/left/right/fire) plus coin and start buttons, all in the clk_sys domain.
- Synchronises and debounces every button, then converts each player's 8-way direction into the two-lever tread commands the core expects.
- Drives the core's active-low Joy*/Coin/Start pins and active-high Fire pins, inserting a reversal dead time so a tread never flips directly between forward and back.

Parameters:
- DEB_CYCLES, 120000: consecutive stable cycles before a debounced bit changes (10 ms at 12 MHz); must be >= 1.
- COIN_PULSE, 240000: cycles the coin output is held active per accepted coin press; must be >= 1.
- REV_GAP, 12000: cycles both Fw and Bk of a tread are held inactive on a direct forward<->back reversal; 0 disables the gap.

Ports:
- clk_sys, in, 1: system clock (12 MHz).
- Reset_n, in, 1: asynchronous active-low reset.
- p1_dir_i, in, 4: player 1 {up,down,left,right}, active-high, raw.
- p2_dir_i, in, 4: player 2 {up,down,left,right}, active-high, raw.
- fire_i, in, 2: {p2,p1} fire, active-high, raw.
- coin_i, in, 1: coin, active-high, raw.
- start_i, in, 2: {start2,start1}, active-high, raw.
- JoyW_Fw_O, JoyW_Bk_O, JoyX_Fw_O, JoyX_Bk_O, out, 1 each: player 1 tread commands, active-low.
- JoyY_Fw_O, JoyY_Bk_O, JoyZ_Fw_O, JoyZ_Bk_O, out, 1 each: player 2 tread commands, active-low.
- FireA_O, FireB_O, out, 1 each: player 1 and player 2 fire, active-high.
- Coin_O, out, 1: coin, active-low pulse.
- Start1_O, Start2_O, out, 1 each: start, active-low level.

Behaviour:
- Reset state: all active-low outputs 1; FireA_O/FireB_O 0. All sync flops, debounced bits, counters and the coin FSM are cleared. Reset is asynchronous at assertion and at any point mid-operation, including mid-pulse and mid-gap.
- Synchroniser: 2-flop chain on each of the 13 raw bits.
- Debouncer:
  - One counter per bit, sized clog2(DEB_CYCLES+1).
  - If the synced value equals the debounced value, clear the counter.
  - Otherwise increment; when the counter reaches DEB_CYCLES-1, update the debounced bit and clear the counter.
  - Any glitch shorter than DEB_CYCLES cycles is rejected, because a mismatch interruption restarts the count.
- Input latency: a raw change held stable appears on the debounced bit exactly 2+DEB_CYCLES cycles later. Every output is registered, adding 1 further cycle.
- Direction decode: key {u,d,l,r} -> target {WFw,WBk,XFw,XBk} (active-high internally; W/Y is the left tread, X/Z the right tread). Any other combination gives 0000; this includes none, u+d, l+r and three or more keys.
  - 1010 (up-left) -> 0010
  - 1000 (up) -> 1010
  - 1001 (up-right) -> 1000
  - 0001 (right) -> 1001
  - 0101 (down-right) -> 0100
  - 0100 (down) -> 0101
  - 0110 (down-left) -> 0001
  - 0010 (left) -> 0110
- Reversal gap, per tread (4 independent instances):
  - States IDLE/FW/BK/GAP with a gap counter, sized clog2(REV_GAP+1).
  - IDLE/FW/BK follow the target directly: Fw only -> FW, Bk only -> BK, neither -> IDLE.
  - FW with target Bk, or BK with target Fw: if REV_GAP > 0, enter GAP, output both inactive, and load the counter. Otherwise switch directly.
  - GAP holds for REV_GAP cycles, then enters the state matching the current target. A target change during GAP does not restart the gap.
  - Fw and Bk of one tread are never both active.
- Fire: FireA_O = registered debounced p1 fire; FireB_O = registered debounced p2 fire.
- Start: Start1_O/Start2_O = registered inverted debounced start bits.
- Coin FSM (IDLE/PULSE/WAIT_REL):
  - IDLE: on debounced coin rising, go to PULSE and drive Coin_O=0 for exactly COIN_PULSE cycles.
  - PULSE: on expiry, go to WAIT_REL if coin is still held, else IDLE.
  - WAIT_REL: return to IDLE on coin release. No retrigger is possible without a release.
  - A release and re-press during PULSE is ignored; that press is lost.

Test Plan:
- Reset with all raw inputs 0 (use DEB_CYCLES=4, COIN_PULSE=6, REV_GAP=3) -> all Joy/Coin/Start outputs 1 and both Fire outputs 0; hold them for 20 cycles.
- p1_dir_i=1000 held -> exactly 7 cycles after the raw change, JoyW_Fw_O=0, JoyX_Fw_O=0, JoyW_Bk_O=1, JoyX_Bk_O=1. A 3-cycle pulse of 0001 produces no output change.
- p1 goes from up (1000) directly to down (0100), debounced -> the W and X treads each show 3 cycles of Fw=Bk=1, then Bk_O=0. Going from up to up-right (1001) flips only the X tread to all-inactive, with no gap.
- p2_dir_i=1100 or 0011 or 1110 -> JoyY/Z outputs are all 1. Left (0010) gives JoyY_Bk_O=0 and JoyZ_Fw_O=0.
- coin_i held for 50 cycles -> Coin_O=0 for exactly 6 cycles, then 1. There is no second pulse until release and a fresh press. Asserting Reset_n=0 mid-pulse forces Coin_O=1 immediately.
- fire_i=2'b01 and start_i=2'b10 held -> FireA_O=1, FireB_O=0, Start2_O=0 and Start1_O=1 after 7 cycles.
